// File: rtl/sliding_window.sv
// sliding_window: SIZE x SIZE raster window over a pixel stream, built from WIDTH-deep line delays.
// Defining SLIDING_WINDOW_KERNEL_EN adds a registered 3x3 convolution result on port out.
module sliding_window #(
    parameter int SIZE      = 3,
    parameter int WIDTH     = 800,
    parameter int PRECISION = 12,
    parameter logic signed [3:0] K00 = 4'sd0,
    parameter logic signed [3:0] K01 = 4'sd0,
    parameter logic signed [3:0] K02 = 4'sd0,
    parameter logic signed [3:0] K10 = 4'sd0,
    parameter logic signed [3:0] K11 = 4'sd1,
    parameter logic signed [3:0] K12 = 4'sd0,
    parameter logic signed [3:0] K20 = 4'sd0,
    parameter logic signed [3:0] K21 = 4'sd0,
    parameter logic signed [3:0] K22 = 4'sd0
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic signed [PRECISION-1:0]                   pixel_in,
    output logic signed [SIZE-1:0][SIZE-1:0][PRECISION-1:0] buffer
`ifdef SLIDING_WINDOW_KERNEL_EN
    ,
    output logic signed [PRECISION-1:0]                   out
`endif
);

    // Each line memory plus its read register plus the column-0 tap spans exactly WIDTH cycles.
    localparam int DEPTH = WIDTH - 1;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    // line_rd[r] feeds column 0 of window row r; row 0 takes the live pixel.
    logic signed [PRECISION-1:0] line_rd [SIZE];

    assign line_rd[0] = pixel_in;

    generate
        if (SIZE > 1) begin : g_lines
            logic [PTR_W-1:0] ptr_reg;
            logic [CNT_W-1:0] cnt_reg;
            logic             full;

            // Memories are never cleared; reads stay masked to 0 until every slot holds post-reset data.
            assign full = (cnt_reg == CNT_W'(DEPTH));

            always_ff @(posedge clk) begin
                if (reset) begin
                    ptr_reg <= '0;
                    cnt_reg <= '0;
                end else begin
                    ptr_reg <= (ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : ptr_reg + 1'b1;
                    if (!full) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            for (genvar gi = 1; gi < SIZE; gi++) begin : g_row
                logic signed [PRECISION-1:0] mem [DEPTH];
                logic signed [PRECISION-1:0] rd_reg;

                always_ff @(posedge clk) begin
                    mem[ptr_reg] <= line_rd[gi-1];
                end

                always_ff @(posedge clk) begin
                    if (reset || !full) begin
                        rd_reg <= '0;
                    end else begin
                        rd_reg <= mem[ptr_reg];
                    end
                end

                assign line_rd[gi] = rd_reg;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            buffer <= '0;
        end else begin
            for (int r = 0; r < SIZE; r++) begin
                buffer[r][0] <= line_rd[r];
                for (int c = 1; c < SIZE; c++) begin
                    buffer[r][c] <= buffer[r][c-1];
                end
            end
        end
    end

`ifdef SLIDING_WINDOW_KERNEL_EN
    generate
        if (SIZE != 3) begin : g_size_check
            $error("sliding_window: the convolution kernel requires SIZE == 3");
        end
    endgenerate

    // Nine 4-bit x PRECISION products summed: PRECISION+8 bits never overflows.
    localparam int SUM_W = PRECISION + 8;
    localparam logic signed [3:0] KMAT [3][3] = '{'{K00, K01, K02},
                                                  '{K10, K11, K12},
                                                  '{K20, K21, K22}};

    logic signed [SUM_W-1:0] sum;

    always_comb begin
        sum = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                sum = sum + SUM_W'(KMAT[r][c]) * SUM_W'($signed(buffer[r][c]));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out <= '0;
        end else begin
            out <= PRECISION'(sum);
        end
    end
`endif

endmodule

// File: tb/tb_sliding_window.sv
// Directed bench for sliding_window: table-driven ramp vectors plus reset, constant and random sequences.
module tb_sliding_window;
    localparam int W = 4;
    localparam int P = 12;

    typedef struct {
        int n;
        int kind;
        int r;
        int c;
        int exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic signed [P-1:0] px = '0;
    logic signed [7:0]   px8;
    logic signed [2:0][2:0][P-1:0] buf_w;

    int n_checks = 0;
    int n_pass   = 0;
    int hist [12];
    vec_t tbl [$];

    assign px8 = px[7:0];

    always #5 clk = ~clk;

`ifdef SLIDING_WINDOW_KERNEL_EN
    logic signed [P-1:0]           id_out;
    logic signed [P-1:0]           sob_out;
    logic signed [2:0][2:0][P-1:0] sob_buf;
    logic signed [7:0]             p8_out;
    logic signed [2:0][2:0][7:0]   p8_buf;
`endif

    sliding_window #(.SIZE(3), .WIDTH(W), .PRECISION(P)) u_dut (
        .clk      (clk),
        .reset    (rst),
        .pixel_in (px),
        .buffer   (buf_w)
`ifdef SLIDING_WINDOW_KERNEL_EN
        ,
        .out      (id_out)
`endif
    );

`ifdef SLIDING_WINDOW_KERNEL_EN
    sliding_window #(.SIZE(3), .WIDTH(W), .PRECISION(P),
                     .K00(4'sd1), .K01(4'sd2), .K02(4'sd1),
                     .K10(4'sd0), .K11(4'sd0), .K12(4'sd0),
                     .K20(-4'sd1), .K21(-4'sd2), .K22(-4'sd1)) u_sobel (
        .clk      (clk),
        .reset    (rst),
        .pixel_in (px),
        .buffer   (sob_buf),
        .out      (sob_out)
    );

    sliding_window #(.SIZE(3), .WIDTH(W), .PRECISION(8),
                     .K00(4'sd7), .K01(4'sd7), .K02(4'sd7),
                     .K10(4'sd7), .K11(4'sd7), .K12(4'sd7),
                     .K20(4'sd7), .K21(4'sd7), .K22(4'sd7)) u_p8 (
        .clk      (clk),
        .reset    (rst),
        .pixel_in (px8),
        .buffer   (p8_buf),
        .out      (p8_out)
    );

    function automatic int sobel_model();
        int sk [9] = '{1, 2, 1, 0, 0, 0, -1, -2, -1};
        int s = 0;
        logic [31:0] v;
        logic signed [P-1:0] t;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                s += sk[r*3+c] * hist[r*W+c+1];
            end
        end
        v = s;
        t = v[P-1:0];
        return int'(t);
    endfunction
`endif

    // One clock edge; the history model follows the definition of each tap's delay.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < 12; k++) hist[k] = 0;
        end else begin
            for (int k = 11; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = int'(px);
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic int tap(input int r, input int c);
        return int'($signed(buf_w[r][c]));
    endfunction

    task automatic check_window(input string tag);
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                check($sformatf("%s tap%0d%0d", tag, r, c), tap(r, c), hist[r*W+c]);
            end
        end
    endtask

    task automatic add(input int n, input int kind, input int r, input int c, input int exp);
        vec_t v;
        v = '{n, kind, r, c, exp};
        tbl.push_back(v);
    endtask

    initial begin
        int act;

        // Ramp vectors: kind 0 = tap[r][c], 1 = sobel out, 2 = identity out.
        add(5, 0, 1, 0, 1);
        add(5, 0, 1, 1, 0);
        add(5, 0, 2, 0, 0);
        add(9, 0, 2, 0, 1);
        add(9, 0, 2, 1, 0);
        add(20, 0, 0, 0, 20);
        add(20, 0, 1, 0, 16);
        add(20, 0, 2, 2, 10);
        add(20, 0, 1, 1, 15);
        add(20, 0, 0, 2, 18);
        add(20, 0, 2, 1, 11);
`ifdef SLIDING_WINDOW_KERNEL_EN
        add(6, 1, 0, 0, 16);
        add(10, 1, 0, 0, 31);
        add(20, 1, 0, 0, 32);
        add(6, 2, 0, 0, 0);
        add(7, 2, 0, 0, 1);
        add(20, 2, 0, 0, 14);
`endif

        rst = 1'b1;
        px  = '0;
        tick();
        rst = 1'b0;
        check_window("reset");
`ifdef SLIDING_WINDOW_KERNEL_EN
        check("reset id_out", int'(id_out), 0);
        check("reset sob_out", int'(sob_out), 0);
        check("reset p8_out", int'(p8_out), 0);
`endif

        for (int n = 1; n <= 20; n++) begin
            px = P'(n);
            tick();
            foreach (tbl[i]) begin
                if (tbl[i].n == n) begin
                    act = 0;
                    case (tbl[i].kind)
                        0: act = tap(tbl[i].r, tbl[i].c);
`ifdef SLIDING_WINDOW_KERNEL_EN
                        1: act = int'(sob_out);
                        2: act = int'(id_out);
`endif
                        default: act = 0;
                    endcase
                    check($sformatf("ramp n=%0d kind%0d r%0d c%0d", n, tbl[i].kind, tbl[i].r, tbl[i].c),
                          act, tbl[i].exp);
                end
            end
        end

        do_reset();
        for (int n = 1; n <= 14; n++) begin
            px = 12'sd50;
            tick();
`ifdef SLIDING_WINDOW_KERNEL_EN
            if (n == 3) check("const50 sobel fill", int'(sob_out), 150);
`endif
        end
        check_window("const50");
`ifdef SLIDING_WINDOW_KERNEL_EN
        check("const50 sobel full", int'(sob_out), 0);
`endif

        do_reset();
        for (int n = 1; n <= 14; n++) begin
            px = 12'sd100;
            tick();
`ifdef SLIDING_WINDOW_KERNEL_EN
            if (n == 2) check("p8 wrap fill", int'(p8_out), -68);
`endif
        end
`ifdef SLIDING_WINDOW_KERNEL_EN
        check("p8 wrap full", int'(p8_out), -100);
`endif

        // Reset mid-line: stale line-memory contents must never reappear.
        do_reset();
        for (int n = 1; n <= 10; n++) begin
            px = P'(n);
            tick();
        end
        rst = 1'b1;
        px  = 12'sd77;
        tick();
        rst = 1'b0;
        check_window("midreset");
`ifdef SLIDING_WINDOW_KERNEL_EN
        check("midreset id_out", int'(id_out), 0);
`endif
        for (int n = 0; n < 12; n++) begin
            px = P'(100 + n);
            tick();
            check_window($sformatf("after_reset%0d", n));
        end

        for (int n = 0; n < 30; n++) begin
            px = P'(int'($urandom_range(0, 4095)) - 2048);
            tick();
            check_window($sformatf("rand%0d", n));
`ifdef SLIDING_WINDOW_KERNEL_EN
            check($sformatf("rand%0d id_out", n), int'(id_out), hist[6]);
            check($sformatf("rand%0d sob_out", n), int'(sob_out), sobel_model());
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
